// File: rtl/dmem_responder.sv
// Byte-addressable RV32I data memory with a single outstanding request and fixed access latency.
// Response appears LATENCY cycles after accept and is held until resp_ready; req_ready is low while busy.
module dmem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_func3;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          out_of_range;
    logic          misaligned;
    logic          illegal;
    logic          err;
    logic          do_access;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic [31:0]   wd;
    logic [3:0]    be;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign idx       = lat_addr[AW+1:2];
    assign lane      = lat_addr[1:0];
    assign do_access = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        out_of_range = ({2'b00, lat_addr[31:2]} >= 32'(DEPTH_WORDS));
        misaligned   = ((lat_func3[1:0] == 2'b01) && lat_addr[0]) ||
                       ((lat_func3 == 3'b010) && (lat_addr[1:0] != 2'b00));
        if (lat_we)
            illegal = !((lat_func3 == 3'b000) || (lat_func3 == 3'b001) || (lat_func3 == 3'b010));
        else
            illegal = (lat_func3 == 3'b011) || (lat_func3 == 3'b110) || (lat_func3 == 3'b111);
        err = out_of_range || misaligned || illegal;
    end

    // Only index storage when in range so the read never leaves the array.
    always_comb begin
        word = out_of_range ? 32'd0 : mem[idx];
        shifted = word >> {lane, 3'b000};
        case (lat_func3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        wd = lat_wdata;
        be = 4'b0000;
        case (lat_func3)
            3'b000: begin
                wd = {4{lat_wdata[7:0]}};
                be = 4'b0001 << lane;
            end
            3'b001: begin
                wd = {2{lat_wdata[15:0]}};
                be = lane[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                wd = lat_wdata;
                be = 4'b1111;
            end
            default: begin
                wd = lat_wdata;
                be = 4'b0000;
            end
        endcase
    end

    // Storage is never reset; a reset landing on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && lat_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_func3 <= req_func3;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rdata_q <= (err || lat_we) ? 32'd0 : load_val;
                        err_q   <= err;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of load/store transactions plus reset and backpressure sequences.
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int DW  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_func3  (req_func3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drives one request, scrambles the inputs while busy, checks latency, data, hold behaviour and handshake.
    task automatic do_req(input string nm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int cyc;
        @(negedge clk);
        check({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_func3 = f3;
        @(posedge clk);
        #1;
        req_we     = ~we;
        req_addr   = addr ^ 32'h4;
        req_wdata  = ~wdata;
        req_func3  = 3'b010;
        resp_ready = 1'b1;
        check({nm, "_busy"}, 32'(req_ready), 32'd0);
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check({nm, "_latency"}, 32'(cyc), 32'(LAT));
        check({nm, "_rdata"}, resp_rdata, exp_rd);
        check({nm, "_err"}, 32'(resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
            check({nm, "_hold_rdata"}, resp_rdata, exp_rd);
            check({nm, "_hold_err"}, 32'(resp_err), 32'(exp_err));
            check({nm, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({nm, "_post_req_ready"}, 32'(req_ready), 32'd1);
        check({nm, "_post_resp_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_func3  = 3'd0;
        resp_ready = 1'b0;

        vecs.push_back('{"sw_10",      1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{"lw_10",      1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"sw_10_zero", 1'b1, 32'h10,  32'h0,        3'b010, 32'h0,        1'b0});
        vecs.push_back('{"sb_13",      1'b1, 32'h13,  32'h80,       3'b000, 32'h0,        1'b0});
        vecs.push_back('{"lb_13",      1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{"lbu_13",     1'b0, 32'h13,  32'h0,        3'b100, 32'h00000080, 1'b0});
        vecs.push_back('{"lw_10_sb",   1'b0, 32'h10,  32'h0,        3'b010, 32'h80000000, 1'b0});
        vecs.push_back('{"sh_12",      1'b1, 32'h12,  32'h8001,     3'b001, 32'h0,        1'b0});
        vecs.push_back('{"lh_12",      1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFF8001, 1'b0});
        vecs.push_back('{"lhu_12",     1'b0, 32'h12,  32'h0,        3'b101, 32'h00008001, 1'b0});
        vecs.push_back('{"sh_11_mis",  1'b1, 32'h11,  32'hFFFF,     3'b001, 32'h0,        1'b1});
        vecs.push_back('{"lw_10_sh",   1'b0, 32'h10,  32'h0,        3'b010, 32'h80010000, 1'b0});
        vecs.push_back('{"lw_400_oor", 1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        1'b1});
        vecs.push_back('{"ld_f3_011",  1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1});
        vecs.push_back('{"sw_12_mis",  1'b1, 32'h12,  32'h11111111, 3'b010, 32'h0,        1'b1});
        vecs.push_back('{"st_f3_100",  1'b1, 32'h10,  32'h22222222, 3'b100, 32'h0,        1'b1});
        vecs.push_back('{"lh_13_mis",  1'b0, 32'h13,  32'h0,        3'b001, 32'h0,        1'b1});
        vecs.push_back('{"lw_10_kept", 1'b0, 32'h10,  32'h0,        3'b010, 32'h80010000, 1'b0});
        vecs.push_back('{"lb_12",      1'b0, 32'h12,  32'h0,        3'b000, 32'h00000001, 1'b0});
        vecs.push_back('{"sw_3fc",     1'b1, 32'h3FC, 32'hA5A55A5A, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{"lhu_3fe",    1'b0, 32'h3FE, 32'h0,        3'b101, 32'h0000A5A5, 1'b0});
        vecs.push_back('{"lb_3fc",     1'b0, 32'h3FC, 32'h0,        3'b000, 32'h0000005A, 1'b0});
        vecs.push_back('{"sw_20_zero", 1'b1, 32'h20,  32'h0,        3'b010, 32'h0,        1'b0});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_rdata", resp_rdata, 32'd0);
        check("reset_err", 32'(resp_err), 32'd0);

        foreach (vecs[i])
            do_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].func3,
                   vecs[i].exp_rdata, vecs[i].exp_err, 0);

        // Backpressure for five cycles, then an immediate follow-on request.
        do_req("lw_10_hold", 1'b0, 32'h10, 32'h0, 3'b010, 32'h80010000, 1'b0, 5);
        do_req("lw_10_b2b", 1'b0, 32'h10, 32'h0, 3'b010, 32'h80010000, 1'b0, 0);

        // Reset in WAIT aborts a store; a request offered during reset must be ignored.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_func3 = 3'b010;
        @(posedge clk);
        #1;
        check("rstwait_accepted", 32'(req_ready), 32'd0);
        rst       = 1'b1;
        req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        check("rstwait_req_ready", 32'(req_ready), 32'd1);
        check("rstwait_resp_valid", 32'(resp_valid), 32'd0);
        check("rstwait_rdata", resp_rdata, 32'd0);
        check("rstwait_err", 32'(resp_err), 32'd0);
        seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid)
                seen++;
        end
        check("rstwait_no_resp", 32'(seen), 32'd0);
        do_req("lw_20_after_rst", 1'b0, 32'h20, 32'h0, 3'b010, 32'h00000000, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
